// File: rtl/disp_pkg.sv
// Shared constants and helpers for the four-digit 7-segment scan controller.
// Patterns and anode enables are active-low throughout.
package disp_pkg;

  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } phase_t;

  // Active-low one-cold anode enable for a digit index.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    an_select = AN_OFF & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/mod_m_counter.sv
// Wrap-around counter from 0 to M-1 with a max_tick flag while holding M-1.
// max_tick is combinational so the caller can act on the wrapping edge itself.
module mod_m_counter #(
  parameter int N = 16,
  parameter int M = 2 ** N
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic [N-1:0] q,
  output logic         max_tick
);

  localparam logic [N-1:0] LAST = N'(M - 1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (q == LAST) begin
      q <= '0;
    end else begin
      q <= q + 1'b1;
    end
  end

  assign max_tick = (q == LAST);

endmodule

// File: rtl/disp_mux_ctrl.sv
// Time-multiplexed scan of four 7-segment digits over one shared segment bus,
// with per-slot dead-time and a per-frame snapshot of the digit inputs.
module disp_mux_ctrl
  import disp_pkg::*;
#(
  parameter int N   = 16,
  parameter int GAP = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] blank,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam logic [N-1:0] GAP_CNT = N'(GAP);

  logic [N-1:0] cnt;
  logic         slot_end;
  logic [1:0]   idx;
  logic         frame_end;
  logic [7:0]   sh_in [NUM_DIGITS];
  logic [3:0]   sh_blank;
  phase_t       phase;
  logic [3:0]   an_next;
  logic [7:0]   sseg_next;

  mod_m_counter #(
    .N(N)
  ) u_slot_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .q        (cnt),
    .max_tick (slot_end)
  );

  assign frame_end = slot_end && (idx == 2'd3);

  // Outputs are decided from the current (idx, cnt) and the current snapshot,
  // so the boundary edge still shows digit 3 from the old frame.
  always_comb begin
    phase     = (cnt < GAP_CNT) ? PH_DEAD : PH_ON;
    an_next   = AN_OFF;
    sseg_next = SSEG_BLANK;
    if (phase == PH_ON && !sh_blank[idx]) begin
      an_next   = an_select(idx);
      sseg_next = sh_in[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx        <= 2'd0;
      an         <= AN_OFF;
      sseg       <= SSEG_BLANK;
      frame_tick <= 1'b0;
      sh_blank   <= AN_OFF;
      for (int i = 0; i < NUM_DIGITS; i++) sh_in[i] <= SSEG_BLANK;
    end else begin
      an         <= an_next;
      sseg       <= sseg_next;
      frame_tick <= frame_end;
      if (slot_end) idx <= idx + 2'd1;
      if (frame_end) begin
        sh_in[0] <= in0;
        sh_in[1] <= in1;
        sh_in[2] <= in2;
        sh_in[3] <= in3;
        sh_blank <= blank;
      end
    end
  end

endmodule

// File: tb/tb_disp_mux_ctrl.sv
// Scoreboard bench for disp_mux_ctrl with a 16-cycle slot and 2-cycle dead-time.
module tb_disp_mux_ctrl;

  localparam int N    = 4;
  localparam int GAP  = 2;
  localparam int SLOT = 16;
  localparam int W    = 13;  // {frame_tick, an, sseg}

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] blank;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  disp_mux_ctrl #(.N(N), .GAP(GAP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .blank      (blank),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  // Reference state: counters as held by the DUT in the current cycle.
  int         m_cnt;
  int         m_idx;
  logic [7:0] m_sh [4];
  logic [3:0] m_blank;

  // Per-segment tallies of observed behaviour.
  int         lit_cycles;
  int         tick_cycles;
  logic [7:0] last_d2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predict the outputs of the coming edge, advance the model, clock, compare.
  task automatic step();
    logic [3:0]   e_an;
    logic [7:0]   e_sseg;
    logic         e_tick;
    logic [W-1:0] e;
    logic [7:0]   cur_in [4];
    cur_in[0] = in0; cur_in[1] = in1; cur_in[2] = in2; cur_in[3] = in3;
    if (!reset_n) begin
      e_an = 4'hF; e_sseg = 8'hFF; e_tick = 1'b0;
      m_cnt = 0; m_idx = 0; m_blank = 4'hF;
      for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
    end else begin
      e_an = 4'hF; e_sseg = 8'hFF;
      if (m_cnt >= GAP && !m_blank[m_idx]) begin
        e_an = 4'hF;
        e_an[m_idx] = 1'b0;
        e_sseg = m_sh[m_idx];
      end
      e_tick = (m_idx == 3) && (m_cnt == SLOT - 1);
      if (e_tick) begin
        for (int i = 0; i < 4; i++) m_sh[i] = cur_in[i];
        m_blank = blank;
      end
      if (m_cnt == SLOT - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
    exp_q.push_back({e_tick, e_an, e_sseg});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("an", 32'(an), 32'(e[11:8]));
      check("sseg", 32'(sseg), 32'(e[7:0]));
      check("frame_tick", 32'(frame_tick), 32'(e[12]));
    end
    check("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    if (an != 4'hF) lit_cycles++;
    if (frame_tick) tick_cycles++;
    if (an == 4'b1011) last_d2 = sseg;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_tallies();
    lit_cycles = 0;
    tick_cycles = 0;
    last_d2 = 8'h00;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1) assert ($countones(~an) <= 1);
  end

  initial begin
    int guard;
    reset_n = 1'b0;
    in0 = 8'hC0; in1 = 8'hF9; in2 = 8'hA4; in3 = 8'hB0;
    blank = 4'b0000;
    m_cnt = 0; m_idx = 0; m_blank = 4'hF;
    for (int i = 0; i < 4; i++) m_sh[i] = 8'hFF;
    #2;

    // Reset held for three cycles.
    run(3);
    check("reset_an", 32'(an), 32'hF);
    check("reset_sseg", 32'(sseg), 32'hFF);
    check("reset_tick", 32'(frame_tick), 32'd0);

    // First frame after release stays dark; tick lands in its last cycle.
    reset_n = 1'b1;
    clear_tallies();
    run(64);
    check("first_frame_lit", 32'(lit_cycles), 32'd0);
    check("first_frame_ticks", 32'(tick_cycles), 32'd1);
    check("first_frame_tick_last", 32'(frame_tick), 32'd1);

    // Normal scan: 4 digits x 14 lit cycles; change in2 while digit 1 scans.
    clear_tallies();
    run(SLOT + 5);
    in2 = 8'h99;
    run(64 - SLOT - 5);
    check("scan_lit", 32'(lit_cycles), 32'd56);
    check("scan_ticks", 32'(tick_cycles), 32'd1);
    check("midframe_old_d2", 32'(last_d2), 32'hA4);

    clear_tallies();
    run(64);
    check("newframe_d2", 32'(last_d2), 32'h99);

    // Blanking digits 1 and 3: only digits 0 and 2 light.
    blank = 4'b1010;
    in0 = 8'(($urandom_range(0, 255)));
    run(64);
    clear_tallies();
    run(64);
    check("blank_lit", 32'(lit_cycles), 32'd28);
    check("blank_d2", 32'(last_d2), 32'h99);

    // Random pattern frames.
    blank = 4'(($urandom_range(0, 15)));
    in1 = 8'(($urandom_range(0, 255)));
    in3 = 8'(($urandom_range(0, 255)));
    run(128);

    // Reset in the middle of digit 2's slot.
    blank = 4'b0000;
    guard = 0;
    while (!(m_idx == 2 && m_cnt == 9) && guard < 200) begin
      step();
      guard++;
    end
    check("midslot_reach", 32'(guard < 200), 32'd1);
    reset_n = 1'b0;
    step();
    check("midslot_reset_an", 32'(an), 32'hF);
    reset_n = 1'b1;
    clear_tallies();
    run(64);
    check("midslot_dark_frame", 32'(lit_cycles), 32'd0);
    clear_tallies();
    run(64);
    check("post_reset_lit", 32'(lit_cycles), 32'd56);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
